// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and
// the default operand width.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_fa_cell.sv
// Combinational full adder: two half-adder stages whose carries are ORed.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic hs1_sum;
  logic hs1_carry;
  logic hs2_carry;

  // First half adder combines the operand bits, second folds in the carry.
  assign hs1_sum   = a ^ b;
  assign hs1_carry = a & b;
  assign s         = hs1_sum ^ cin;
  assign hs2_carry = hs1_sum & cin;
  assign cout      = hs1_carry | hs2_carry;

endmodule : fa_cell

// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands LSB-first, one bit per
// clock, with a start/busy/done handshake. {cout,sum} = a + b + cin.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [WIDTH-1:0]   a_sr;
  logic [WIDTH-1:0]   b_sr;
  logic               carry;
  logic [CNT_W-1:0]   count;
  logic               bit_sum;
  logic               bit_carry;

  // Single full-adder cell shared by every bit position.
  fa_cell u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .s    (bit_sum),
    .cout (bit_carry)
  );

  // Status outputs decode straight from the state register, so they carry
  // no combinational path from any input.
  assign busy = (state == RUN);
  assign done = (state == DONE);

  // FSM, operand shift registers, carry flop, bit counter and result.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, e.g. sum shifts in the bit computed from the
  // old a_sr/b_sr/carry rather than the already-shifted ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      carry <= 1'b0;
      count <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            count <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            state <= RUN;
          end
        end
        RUN: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          carry <= bit_carry;
          sum   <= {bit_sum, sum[WIDTH-1:1]};
          count <= count + CNT_W'(1);
          if (count == LAST_BIT) begin
            cout  <= bit_carry;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases plus a random sweep
// compared against plain integer addition.
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int tests_run;
  int tests_failed;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: the sum as a (WIDTH+1)-bit number.
  function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y,
                                             input logic ci);
    int unsigned r;
    r = int'(x) + int'(y) + int'(ci);
    return r[WIDTH:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch one addition from IDLE and check latency, busy span, result and
  // done pulse width. With disturb set, a second start with different
  // operands is presented mid-run and must have no effect.
  task automatic do_add(input string tag, input logic [WIDTH-1:0] xa,
                        input logic [WIDTH-1:0] xb, input logic xc,
                        input bit disturb);
    logic [WIDTH:0] exp;
    int             lat;
    int             busy_cycles;
    int             extra_done;
    exp         = ref_add(xa, xb, xc);
    lat         = -1;
    busy_cycles = 0;
    a = xa; b = xb; cin = xc; start = 1'b1;
    step();
    start = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
    for (int i = 1; i <= WIDTH + 4; i++) begin
      if (disturb && i == 3) begin
        start = 1'b1;
        a = ~xa; b = ~xb; cin = ~xc;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        lat = i;
        break;
      end
      if (busy) busy_cycles++;
      step();
    end
    start = 1'b0;
    if (lat < 0) begin
      check({tag, "_done_timeout"}, 32'd0, 32'd1);
    end else begin
      check({tag, "_latency"}, 32'(lat), 32'(WIDTH + 1));
      check({tag, "_busy_cycles"}, 32'(busy_cycles), 32'(WIDTH));
      check({tag, "_result"}, 32'({cout, sum}), 32'(exp));
      check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
      step();
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
      check({tag, "_hold"}, 32'({cout, sum}), 32'(exp));
      if (disturb) begin
        extra_done = 0;
        for (int i = 0; i < WIDTH + 4; i++) begin
          if (done || busy) extra_done++;
          step();
        end
        check({tag, "_no_extra_run"}, 32'(extra_done), 32'd0);
        check({tag, "_hold_late"}, 32'({cout, sum}), 32'(exp));
      end
    end
  endtask

  initial begin
    int done_times[$];
    int cyc;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             rc;

    tests_run    = 0;
    tests_failed = 0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    step();
    step();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", 32'({cout, sum}), 32'd0);
    rst_n = 1'b1;
    step();

    do_add("basic_5a_3c", 8'h5A, 8'h3C, 1'b0, 1'b0);
    do_add("ff_plus_01", 8'hFF, 8'h01, 1'b0, 1'b0);
    do_add("ff_ff_cin", 8'hFF, 8'hFF, 1'b1, 1'b0);
    do_add("zero", 8'h00, 8'h00, 1'b0, 1'b0);
    do_add("midrun_start", 8'h12, 8'h34, 1'b1, 1'b1);

    // Reset in the middle of a run abandons the addition.
    a = 8'hA5; b = 8'h5A; cin = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_done", 32'(done), 32'd0);
    check("midreset_result", 32'({cout, sum}), 32'd0);
    step();
    check("midreset_idle", 32'(busy), 32'd0);
    do_add("after_reset", 8'h10, 8'h20, 1'b0, 1'b0);

    // Start held high: back-to-back additions every WIDTH+2 cycles.
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    cyc = 0;
    for (int i = 0; i < 4 * (WIDTH + 2) + 2; i++) begin
      step();
      cyc++;
      if (done) begin
        done_times.push_back(cyc);
        check("held_result", 32'({cout, sum}), 32'h002);
      end
    end
    start = 1'b0;
    check("held_pulse_count", 32'(done_times.size()), 32'd4);
    for (int i = 1; i < done_times.size(); i++)
      check("held_period", 32'(done_times[i] - done_times[i-1]), 32'(WIDTH + 2));
    for (int i = 0; i < WIDTH + 4; i++) step();
    check("held_drain_idle", 32'(busy | done), 32'd0);

    // Random sweep against the arithmetic reference.
    for (int n = 0; n < 1000; n++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rc = 1'($urandom);
      do_add("random", ra, rb, rc, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_serial_adder
